// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the registered ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_NOT = 3'b101;
  localparam alu_op_t ALU_SHL = 3'b110;
  localparam alu_op_t ALU_SHR = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes the next result and carry from operands and opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] next_result,
  output logic             next_carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow; carry is its inverse.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    unique case (op)
      ALU_ADD: begin
        next_result = sum[WIDTH-1:0];
        next_carry  = sum[WIDTH];
      end
      ALU_SUB: begin
        next_result = diff[WIDTH-1:0];
        next_carry  = ~diff[WIDTH];
      end
      ALU_AND: next_result = a & b;
      ALU_OR:  next_result = a | b;
      ALU_XOR: next_result = a ^ b;
      ALU_NOT: next_result = ~a;
      ALU_SHL: begin
        next_result = {a[WIDTH-2:0], 1'b0};
        next_carry  = a[WIDTH-1];
      end
      ALU_SHR: begin
        next_result = {1'b0, a[WIDTH-1:1]};
        next_carry  = a[0];
      end
      default: begin
        next_result = '0;
        next_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered ALU top: one-cycle latency output register around alu_core with synchronous reset.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a          (a),
    .b          (b),
    .op         (op),
    .next_result(next_result),
    .next_carry (next_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
    end else begin
      result <= next_result;
      carry  <= next_carry;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: driver queues hand-computed expectations, monitor checks each edge.
module tb_alu_8bit;
  import alu_pkg::*;

  typedef struct {
    logic [7:0]  r;
    logic        c;
    int unsigned id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  alu_op_t    op;
  logic [7:0] result;
  logic       carry;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned vec_id   = 0;

  alu_8bit #(
    .WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .op    (op),
    .result(result),
    .carry (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one edge's worth of inputs and queue the value expected after that edge.
  task automatic apply(input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input alu_op_t vop, input logic [7:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    op  = vop;
    e.r  = er;
    e.c  = ec;
    e.id = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  // Monitor: every output presented after an edge that had queued stimulus is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (result !== e.r || carry !== e.c) begin
          failures++;
          $display("FAIL vec%0d: got result=%02h carry=%0b, expected result=%02h carry=%0b",
                   e.id, result, carry, e.r, e.c);
        end
      end
    end
  end

  initial begin
    int unsigned waited;
    rst = 1'b1;
    a   = 8'h00;
    b   = 8'h00;
    op  = ALU_ADD;

    // Reset holds outputs at zero regardless of operands; release computes 0xFF+0x01.
    apply(1'b1, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b0);
    apply(1'b1, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b0);
    apply(1'b0, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1);

    // One vector per opcode.
    apply(1'b0, 8'd10, 8'd5, ALU_ADD, 8'h0F, 1'b0);
    apply(1'b0, 8'd15, 8'd3, ALU_SUB, 8'h0C, 1'b1);
    apply(1'b0, 8'd12, 8'd7, ALU_AND, 8'h04, 1'b0);
    apply(1'b0, 8'd12, 8'd7, ALU_OR,  8'h0F, 1'b0);
    apply(1'b0, 8'd12, 8'd7, ALU_XOR, 8'h0B, 1'b0);
    apply(1'b0, 8'd12, 8'd7, ALU_NOT, 8'hF3, 1'b0);
    apply(1'b0, 8'd12, 8'd7, ALU_SHL, 8'h18, 1'b0);
    apply(1'b0, 8'd12, 8'd7, ALU_SHR, 8'h06, 1'b0);

    // Add carry-out.
    apply(1'b0, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1);
    apply(1'b0, 8'h80, 8'h80, ALU_ADD, 8'h00, 1'b1);
    apply(1'b0, 8'hFE, 8'h05, ALU_ADD, 8'h03, 1'b1);

    // Subtract borrow and equality.
    apply(1'b0, 8'h00, 8'h01, ALU_SUB, 8'hFF, 1'b0);
    apply(1'b0, 8'h02, 8'h05, ALU_SUB, 8'hFD, 1'b0);
    apply(1'b0, 8'h05, 8'h05, ALU_SUB, 8'h00, 1'b1);

    // Shift-out; b nonzero to confirm it is ignored.
    apply(1'b0, 8'h81, 8'hFF, ALU_SHL, 8'h02, 1'b1);
    apply(1'b0, 8'h81, 8'hFF, ALU_SHR, 8'h40, 1'b1);
    apply(1'b0, 8'hA5, 8'h3C, ALU_NOT, 8'h5A, 1'b0);

    // Back-to-back stream with a single-cycle reset in the middle.
    apply(1'b0, 8'h33, 8'h11, ALU_ADD, 8'h44, 1'b0);
    apply(1'b0, 8'h33, 8'h11, ALU_XOR, 8'h22, 1'b0);
    apply(1'b1, 8'hF0, 8'h20, ALU_ADD, 8'h00, 1'b0);
    apply(1'b0, 8'hF0, 8'h20, ALU_ADD, 8'h10, 1'b1);
    apply(1'b0, 8'h10, 8'h20, ALU_SUB, 8'hF0, 1'b0);
    apply(1'b0, 8'hF0, 8'h0F, ALU_OR,  8'hFF, 1'b0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
